// File: rtl/reduce_pkg.sv
// Shared types and constants for the lane reduction block.
// Depth typedefs are sized for the default compare width.
package reduce_pkg;

    localparam int DEPTH_W   = 18;
    localparam int FB_ADDR_W = 20;
    localparam int BRI_W     = 8;

    localparam logic [15:0] TRI_COUNT_MAX = 16'hFFFF;

    typedef logic signed [DEPTH_W-1:0] lane_depth_t;

    typedef struct packed {
        logic             hit;
        lane_depth_t      oa;
        lane_depth_t      t;
        logic [BRI_W-1:0] bri;
    } lane_cand_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == TRI_COUNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/reduce_lane.sv
// One pixel lane: keeps the nearest candidate (depth = t/oa) seen in the current group.
// Optional near-plane rejection is enabled by REDUCE_NEAR_CLIP_EN.
module reduce_lane
    import reduce_pkg::*;
#(
    parameter int W = DEPTH_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_d,
    input  logic                 last_tri_d,
    input  logic                 hit_d,
    input  logic signed [W-1:0]  oa_d,
    input  logic signed [W-1:0]  t_d,
    input  logic [BRI_W-1:0]     bri_d,
`ifdef REDUCE_NEAR_CLIP_EN
    input  logic signed [W-1:0]  near_t,
`endif
    output logic                 next_hit,
    output logic [BRI_W-1:0]     next_bri
);

    localparam int PW = 2 * W;

    logic                 cur_hit;
    logic signed [W-1:0]  cur_oa;
    logic signed [W-1:0]  cur_t;
    logic [BRI_W-1:0]     cur_bri;

    logic signed [PW-1:0] lhs;
    logic signed [PW-1:0] rhs;
    logic                 better;
    logic                 near_ok;
    logic                 take;

`ifdef REDUCE_NEAR_CLIP_EN
    localparam int NW = PW + 2;
    logic signed [NW-1:0] near_lhs;
    logic signed [NW-1:0] near_abs;
`endif

    always_comb begin
        // NOTE: every combinational output gets a value on every path so no latch is inferred.
        lhs     = PW'(t_d) * PW'(cur_oa);
        rhs     = PW'(cur_t) * PW'(oa_d);
        // Cross-multiplied depth compare; the sign terms undo the inequality flip from negative oa.
        // Equal products are a tie, and a tie keeps the earlier candidate.
        better  = (lhs != rhs) && ((lhs < rhs) ^ oa_d[W-1] ^ cur_oa[W-1]);
        near_ok = 1'b1;
`ifdef REDUCE_NEAR_CLIP_EN
        near_lhs = oa_d[W-1] ? -NW'(t_d)  : NW'(t_d);
        near_abs = oa_d[W-1] ? -NW'(oa_d) : NW'(oa_d);
        near_ok  = near_lhs >= NW'(near_t) * near_abs;
`endif
        take     = hit_d && (oa_d != '0) && near_ok && (!cur_hit || better);
        next_hit = take || cur_hit;
        next_bri = take ? bri_d : cur_bri;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_hit <= 1'b0;
        end else if (valid_d) begin
            cur_hit <= last_tri_d ? 1'b0 : next_hit;
        end
    end

    // NOTE: the candidate payload has no reset; it is only ever read while cur_hit qualifies it.
    always_ff @(posedge clk) begin
        if (valid_d && take) begin
            cur_oa  <= oa_d;
            cur_t   <= t_d;
            cur_bri <= bri_d;
        end
    end

endmodule

// File: rtl/reduce_lanes.sv
// Per-pixel nearest-hit reduction across LANES lanes, one framebuffer write per group.
// Define REDUCE_NEAR_CLIP_EN to add the near_t input and near-plane rejection.
module reduce_lanes
    import reduce_pkg::*;
#(
    parameter int LANES           = 4,
    parameter int TOTAL_PREC      = 27,
    parameter int TOTAL_PREC_COMP = DEPTH_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [FB_ADDR_W-1:0]                fb_addr,
    input  logic                                last_tri,
    input  logic                                last_pix,
    input  logic [LANES-1:0]                    hit,
    input  logic signed [TOTAL_PREC-1:0]        oa [LANES],
    input  logic signed [TOTAL_PREC-1:0]        t [LANES],
    input  logic [BRI_W-1:0]                    bri [LANES],
`ifdef REDUCE_NEAR_CLIP_EN
    input  logic signed [TOTAL_PREC_COMP-1:0]   near_t,
`endif
    output logic                                out_valid,
    output logic [FB_ADDR_W-1:0]                out_addr,
    output logic [LANES-1:0]                    out_hit,
    output logic [BRI_W-1:0]                    out_bri [LANES],
    output logic                                swap,
    output logic [15:0]                         tri_count
);

    localparam int CW  = TOTAL_PREC_COMP;
    localparam int LSB = TOTAL_PREC - TOTAL_PREC_COMP;

    logic                    valid_d;
    logic [FB_ADDR_W-1:0]    fb_addr_d;
    logic                    last_tri_d;
    logic                    last_pix_d;
    logic [LANES-1:0]        hit_d;
    logic signed [CW-1:0]    oa_d [LANES];
    logic signed [CW-1:0]    t_d [LANES];
    logic [BRI_W-1:0]        bri_d [LANES];

    logic [LANES-1:0]        next_hit;
    logic [BRI_W-1:0]        next_bri [LANES];

    logic                    group_end;

    assign group_end = valid_d && last_tri_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d <= 1'b0;
        end else begin
            valid_d <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            fb_addr_d  <= fb_addr;
            last_tri_d <= last_tri;
            last_pix_d <= last_pix;
            hit_d      <= hit;
            for (int i = 0; i < LANES; i++) begin
                oa_d[i]  <= oa[i][TOTAL_PREC-1 -: CW];
                t_d[i]   <= t[i][TOTAL_PREC-1 -: CW];
                bri_d[i] <= bri[i];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        reduce_lane #(
            .W (CW)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .valid_d    (valid_d),
            .last_tri_d (last_tri_d),
            .hit_d      (hit_d[g]),
            .oa_d       (oa_d[g]),
            .t_d        (t_d[g]),
            .bri_d      (bri_d[g]),
`ifdef REDUCE_NEAR_CLIP_EN
            .near_t     (near_t),
`endif
            .next_hit   (next_hit[g]),
            .next_bri   (next_bri[g])
        );

        // Fraction bits below the compare width are dropped on purpose.
        if (LSB > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^{oa[g][LSB-1:0], t[g][LSB-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            swap      <= 1'b0;
            out_addr  <= '0;
            out_hit   <= '0;
            for (int i = 0; i < LANES; i++) begin
                out_bri[i] <= '0;
            end
        end else begin
            out_valid <= group_end;
            swap      <= group_end && last_pix_d;
            if (group_end) begin
                out_addr <= fb_addr_d;
                out_hit  <= next_hit;
                for (int i = 0; i < LANES; i++) begin
                    out_bri[i] <= next_bri[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tri_count <= '0;
        end else if (valid_d) begin
            tri_count <= last_tri_d ? 16'd0 : sat_inc16(tri_count);
        end
    end

endmodule

// File: tb/tb_reduce_lanes.sv
// Directed bench for reduce_lanes: hand-computed groups, ties, sign cases, bubbles, reset.
// Near-clip vectors run only when REDUCE_NEAR_CLIP_EN is defined.
module tb_reduce_lanes;
    import reduce_pkg::*;

    localparam int LANES = 4;
    localparam int TP    = 27;
    localparam int TPC   = 18;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [19:0]          fb_addr;
    logic                 last_tri;
    logic                 last_pix;
    logic [LANES-1:0]     hit;
    logic signed [TP-1:0] oa [LANES];
    logic signed [TP-1:0] t [LANES];
    logic [7:0]           bri [LANES];
`ifdef REDUCE_NEAR_CLIP_EN
    logic signed [TPC-1:0] near_t;
`endif
    logic                 out_valid;
    logic [19:0]          out_addr;
    logic [LANES-1:0]     out_hit;
    logic [7:0]           out_bri [LANES];
    logic                 swap;
    logic [15:0]          tri_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reduce_lanes #(
        .LANES           (LANES),
        .TOTAL_PREC      (TP),
        .TOTAL_PREC_COMP (TPC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .fb_addr   (fb_addr),
        .last_tri  (last_tri),
        .last_pix  (last_pix),
        .hit       (hit),
        .oa        (oa),
        .t         (t),
        .bri       (bri),
`ifdef REDUCE_NEAR_CLIP_EN
        .near_t    (near_t),
`endif
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_hit   (out_hit),
        .out_bri   (out_bri),
        .swap      (swap),
        .tri_count (tri_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic lane_cand_t cand(input logic h, input int tv, input int oav, input int b);
        lane_cand_t c;
        c.hit = h;
        c.t   = lane_depth_t'(tv);
        c.oa  = lane_depth_t'(oav);
        c.bri = 8'(b);
        return c;
    endfunction

    // Candidate depths sit in the MSBs; the truncated fraction bits are zero.
    task automatic set_lane(input int l, input lane_cand_t c);
        hit[l] = c.hit;
        t[l]   = {c.t, {(TP - TPC){1'b0}}};
        oa[l]  = {c.oa, {(TP - TPC){1'b0}}};
        bri[l] = c.bri;
    endtask

    task automatic beat(input logic lt, input logic lp);
        in_valid = 1'b1;
        last_tri = lt;
        last_pix = lp;
        tick();
        in_valid = 1'b0;
        last_tri = 1'b0;
        last_pix = 1'b0;
        hit      = '0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        fb_addr  = '0;
        last_tri = 1'b0;
        last_pix = 1'b0;
        hit      = '0;
        for (int i = 0; i < LANES; i++) begin
            oa[i] = '0; t[i] = '0; bri[i] = '0;
        end
`ifdef REDUCE_NEAR_CLIP_EN
        near_t = '0;
`endif
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_swap", 32'(swap), 32'd0);
        check("rst_out_hit", 32'(out_hit), 32'd0);
        check("rst_tri_count", 32'(tri_count), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_bri0", 32'(out_bri[0]), 32'd0);
        rst = 1'b0;
        tick();

        // Group 1: lane0 depths 2,1,3 -> keeps bri 20; lane2 single hit; lane3 hit with oa=0.
        set_lane(0, cand(1, 4, 2, 10));
        set_lane(3, cand(1, 5, 0, 99));
        beat(0, 0);
        check("g1_tc_beat1", 32'(tri_count), 32'd0);
        set_lane(0, cand(1, 2, 2, 20));
        set_lane(2, cand(1, 5, 1, 77));
        beat(0, 0);
        check("g1_tc_beat2", 32'(tri_count), 32'd1);
        set_lane(0, cand(1, 6, 2, 30));
        fb_addr = 20'h12345;
        beat(1, 0);
        check("g1_tc_beat3", 32'(tri_count), 32'd2);
        check("g1_no_early_valid", 32'(out_valid), 32'd0);
        tick();
        check("g1_out_valid", 32'(out_valid), 32'd1);
        check("g1_swap", 32'(swap), 32'd0);
        check("g1_out_addr", 32'(out_addr), 32'h12345);
        check("g1_out_hit", 32'(out_hit), 32'h5);
        check("g1_out_bri0", 32'(out_bri[0]), 32'd20);
        check("g1_out_bri2", 32'(out_bri[2]), 32'd77);
        check("g1_tc_cleared", 32'(tri_count), 32'd0);
        tick();
        check("g1_valid_one_cycle", 32'(out_valid), 32'd0);

        // Group 2: sign handling and ties across mixed signs.
        set_lane(0, cand(1, 3, 1, 1));
        set_lane(1, cand(1, -3, -1, 3));
        set_lane(2, cand(1, 1, 1, 5));
        set_lane(3, cand(1, 2, 1, 7));
        beat(0, 0);
        set_lane(0, cand(1, -4, -2, 2));
        set_lane(1, cand(1, 4, 2, 4));
        set_lane(2, cand(1, -4, -2, 6));
        set_lane(3, cand(1, -4, -2, 8));
        fb_addr = 20'h00042;
        beat(1, 0);
        tick();
        check("g2_out_hit", 32'(out_hit), 32'hF);
        check("g2_neg_replaces", 32'(out_bri[0]), 32'd2);
        check("g2_flip_replaces", 32'(out_bri[1]), 32'd4);
        check("g2_farther_kept", 32'(out_bri[2]), 32'd5);
        check("g2_signed_tie_kept", 32'(out_bri[3]), 32'd7);

        // Group 3: exact tie keeps first; untouched lanes report no hit.
        set_lane(0, cand(1, 2, 1, 5));
        beat(0, 0);
        set_lane(0, cand(1, 4, 2, 9));
        beat(1, 0);
        tick();
        check("g3_tie_bri", 32'(out_bri[0]), 32'd5);
        check("g3_out_hit", 32'(out_hit), 32'h1);

        // Group 4: single beat carrying last_tri and last_pix.
        set_lane(0, cand(1, 7, 3, 42));
        set_lane(1, cand(1, 7, 0, 43));
        set_lane(3, cand(1, -1, -1, 8));
        fb_addr = 20'hABCDE;
        beat(1, 1);
        check("g4_swap_not_early", 32'(swap), 32'd0);
        tick();
        check("g4_out_valid", 32'(out_valid), 32'd1);
        check("g4_swap", 32'(swap), 32'd1);
        check("g4_out_hit", 32'(out_hit), 32'h9);
        check("g4_out_bri0", 32'(out_bri[0]), 32'd42);
        check("g4_out_bri3", 32'(out_bri[3]), 32'd8);
        check("g4_out_addr", 32'(out_addr), 32'hABCDE);
        tick();
        check("g4_swap_pulse", 32'(swap), 32'd0);
        check("g4_valid_pulse", 32'(out_valid), 32'd0);

        // Group 5: bubbles inside a group keep the accumulated state.
        set_lane(0, cand(1, 2, 1, 11));
        beat(0, 0);
        for (int i = 0; i < 3; i++) tick();
        check("g5_tc_after_bubbles", 32'(tri_count), 32'd1);
        check("g5_no_valid_bubbles", 32'(out_valid), 32'd0);
        set_lane(0, cand(1, 5, 1, 12));
        beat(1, 0);
        tick();
        check("g5_out_valid", 32'(out_valid), 32'd1);
        check("g5_out_bri0", 32'(out_bri[0]), 32'd11);

        // Group 6: interrupted by reset, must vanish.
        set_lane(0, cand(1, 1, 1, 13));
        set_lane(1, cand(1, 1, 1, 13));
        beat(0, 0);
        for (int i = 0; i < 3; i++) tick();
        set_lane(0, cand(1, 1, 1, 13));
        beat(0, 0);
        rst = 1'b1;
        tick();
        check("g6_rst_tc", 32'(tri_count), 32'd0);
        rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                seen += int'(out_valid);
            end
            check("g6_no_output", 32'(seen), 32'd0);
        end

        // Group 7: starts clean after reset.
        set_lane(0, cand(1, 9, 1, 14));
        beat(0, 0);
        tick();
        check("g7_tc_restart", 32'(tri_count), 32'd1);
        beat(1, 0);
        tick();
        check("g7_out_hit", 32'(out_hit), 32'h1);
        check("g7_out_bri0", 32'(out_bri[0]), 32'd14);

`ifdef REDUCE_NEAR_CLIP_EN
        // Near clip at depth 3: depth 2 rejected, depths 3 and 4 accepted.
        near_t = 18'sd3;
        set_lane(0, cand(1, 2, 1, 1));
        set_lane(1, cand(1, 6, 2, 2));
        set_lane(2, cand(1, -8, -2, 3));
        set_lane(3, cand(1, -4, -2, 4));
        beat(1, 0);
        tick();
        check("near_out_hit", 32'(out_hit), 32'h6);
        check("near_out_bri1", 32'(out_bri[1]), 32'd2);
        check("near_out_bri2", 32'(out_bri[2]), 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reduce_lanes.md
REDUCE_LANES -- requirements
Module: reduce_lanes

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning the number of parallel pixel lanes; legal values are 1..16.
REQ-002 SHALL have parameter TOTAL_PREC, default 27, meaning the input oa/t width, signed.
REQ-003 SHALL have parameter TOTAL_PREC_COMP, default 18, meaning the compare width (MSBs kept); TOTAL_PREC_COMP <= TOTAL_PREC.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: input beat qualifier; cycles without it are bubbles.
REQ-007 SHALL have port fb_addr, input, 20 bits: framebuffer address of lane 0 of the group.
REQ-008 SHALL have ports last_tri and last_pix, input, 1 bit each: final triangle of a pixel group, and final group of a frame.
REQ-009 SHALL have ports hit [LANES], oa and t [LANES][TOTAL_PREC] signed, and bri [LANES][8], all inputs: per-lane candidate.
REQ-010 SHALL have ports out_valid (1 bit), out_addr (20 bits), out_hit [LANES] and out_bri [LANES][8], all outputs: one framebuffer write beat.
REQ-011 SHALL have port swap, output, 1 bit: one-cycle pulse, concurrent with the last write of a frame.
REQ-012 SHALL have port tri_count, output, 16 bits: number of triangle beats accumulated in the current group, saturating.

Function
REQ-013 SHALL register all inputs into stage D on every cycle with in_valid=1, truncating oa and t to their TOTAL_PREC_COMP MSBs; valid_d SHALL follow in_valid.
REQ-014 SHALL keep per lane cur_hit, cur_oa, cur_t and cur_bri, updating them only when valid_d=1.
REQ-015 SHALL define "better" as (t_d*cur_oa < cur_t*oa_d) XOR (oa_d<0) XOR (cur_oa<0), evaluated at full 2*TOTAL_PREC_COMP width.
REQ-016 SHALL replace a lane's accumulator when hit_d && oa_d!=0 && (!cur_hit || better); a hit with oa_d==0 SHALL count as a miss.
REQ-017 SHALL keep the earlier candidate on an exact depth tie.
REQ-018 SHALL, on a valid_d beat with last_tri_d=1, load out_hit and out_bri from the next-state values of all lanes, load out_addr from fb_addr_d, and assert out_valid for exactly the following cycle.
REQ-019 SHALL give a latency of 2 cycles from the input last_tri beat to out_valid.
REQ-020 SHALL assert swap together with out_valid when that beat's last_pix_d=1; swap SHALL be 0 otherwise.
REQ-021 SHALL clear every cur_hit on the last_tri_d beat, so that the next group starts empty; a beat carrying last_tri SHALL itself take part in the reduction.
REQ-022 SHALL give a group consisting of a single last_tri beat an output equal to that beat's own hit/bri, after the oa filter.
REQ-023 SHALL increment tri_count on each valid_d beat, saturate it at 16'hFFFF, and reset it to 0 after the last_tri_d beat.
REQ-024 SHALL ignore bubbles between beats of a group without losing state.

Reset
REQ-025 SHALL, while rst=1, clear valid_d, every cur_hit, out_valid, swap, out_hit and tri_count to 0; out_addr and out_bri SHALL go to 0.
REQ-026 SHALL discard a group that is interrupted by rst without producing output, and SHALL treat the first valid beat after reset as the start of a group.

Configuration
REQ-027 SHALL, when REDUCE_NEAR_CLIP_EN is defined, add input near_t (TOTAL_PREC_COMP bits, signed) and treat a hit as a miss unless t_d/oa_d >= near_t, tested sign-correctly as t_d*sign(oa_d) >= near_t*|oa_d|.
REQ-028 SHALL, when REDUCE_NEAR_CLIP_EN is undefined, omit the near_t port and give behaviour identical to REQ-016.

Structure
REQ-029 SHALL place the typedefs lane_depth_t (signed TOTAL_PREC_COMP) and lane_cand_t (hit, oa, t, bri) and the constant TRI_COUNT_MAX in package reduce_pkg.
REQ-030 SHALL implement the per-lane compare-and-hold in sub-module reduce_lane, instantiated LANES times with a generate loop; the top level SHALL hold stage D, the output registers and tri_count.

Verification
REQ-031 SHALL cover: lane 0 receives (t=4,oa=2),(t=2,oa=2),(t=6,oa=2) with bri 10/20/30 and last_tri on the third -> out_bri[0]=20, out_hit[0]=1, 2 cycles after the third beat.
REQ-032 SHALL cover: candidate (t=-4,oa=-2) against current (t=3,oa=1) -> replaced (2<3); the same depths with signs flipped give the same result.
REQ-033 SHALL cover: an exact tie of (2,1) then (4,2) with bri 5 then 9 -> out_bri=5.
REQ-034 SHALL cover: oa=0 with hit=1 as the only candidate -> out_hit=0; all-miss lanes give out_hit=0.
REQ-035 SHALL cover: 3 bubbles inserted mid-group, then rst asserted mid-group -> no out_valid; the next group is independent and tri_count restarts at 0.
REQ-036 SHALL cover: last_tri and last_pix together on one beat -> out_valid=swap=1 in the same cycle for one cycle; with REDUCE_NEAR_CLIP_EN and near_t=3, a hit at depth 2 is rejected.
